// File: rtl/mem_ctlr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctlr_arbiter_if
//  Purpose  : Bundles the cache-side, memory-side and status signals of the
//             icache/dcache memory-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_ctlr_arbiter_if #(
  parameter int XLEN = 32
);
  // dcache request
  logic [1:0]      dcache2ctlr_command;
  logic [XLEN-1:0] dcache2ctlr_addr;
  logic [63:0]     dcache2ctlr_data;
  // icache request
  logic [1:0]      icache2ctlr_command;
  logic [XLEN-1:0] icache2ctlr_addr;
  // memory request
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  // memory return
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  // per-cache copies of the memory return
  logic [3:0]      Ctlr2dcache_response;
  logic [63:0]     Ctlr2dcache_data;
  logic [3:0]      Ctlr2dcache_tag;
  logic [3:0]      Ctlr2icache_response;
  logic [63:0]     Ctlr2icache_data;
  logic [3:0]      Ctlr2icache_tag;
  // status
  logic [3:0]      outstanding_cnt;
  logic            tag_error;

  // Arbiter view: consumes cache requests and memory returns, produces the rest.
  modport slave (
    input  dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    input  icache2ctlr_command, icache2ctlr_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output Ctlr2dcache_response, Ctlr2dcache_data, Ctlr2dcache_tag,
    output Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    output outstanding_cnt, tag_error
  );

  // Environment view: caches plus memory model driving the arbiter.
  modport master (
    output dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    output icache2ctlr_command, icache2ctlr_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  Ctlr2dcache_response, Ctlr2dcache_data, Ctlr2dcache_tag,
    input  Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    input  outstanding_cnt, tag_error
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctlr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctlr_arbiter
//  Purpose  : Shares one memory port between icache and dcache. Grants at most
//             one request per cycle (dcache priority with icache anti-starvation),
//             tracks the owner of each outstanding load tag and steers load
//             completions back to that owner.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctlr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_ctlr_arbiter_if.slave bus
);

  localparam logic [1:0] c_BUS_NONE     = 2'd0;
  localparam logic [1:0] c_BUS_LOAD     = 2'd1;
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [3:0] c_STARVE_MAX   = 4'd15;
  localparam logic       c_OWNER_DC     = 1'b0;
  localparam logic       c_OWNER_IC     = 1'b1;

  logic        w_dc_valid;
  logic        w_ic_valid;
  logic        w_grant_dc;
  logic        w_grant_ic;
  logic [1:0]  w_grant_cmd;
  logic        w_alloc;
  logic        w_cpl_valid;
  logic        w_cpl_hit;
  logic [3:0]  w_starve_nxt;
  logic [15:0] w_tag_valid_nxt;
  logic [15:0] w_tag_owner_nxt;
  logic [3:0]  w_outstanding_nxt;

  logic [3:0]  r_starve_cnt;
  logic [15:0] r_tag_valid;
  logic [15:0] r_tag_owner;
  logic [3:0]  r_outstanding;
  logic        r_tag_error;

  // An icache store is not a legal request and is ignored.
  assign w_dc_valid  = (bus.dcache2ctlr_command != c_BUS_NONE);
  assign w_ic_valid  = (bus.icache2ctlr_command == c_BUS_LOAD);
  assign w_cpl_valid = (bus.mem2proc_tag != 4'd0);
  // Lookup uses the table as it stood before this cycle's allocation.
  assign w_cpl_hit   = w_cpl_valid && r_tag_valid[bus.mem2proc_tag];

  // Grant: dcache wins contention unless icache has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_grant_dc = 1'b0;
    w_grant_ic = 1'b0;
    if (!reset) begin
      if (w_dc_valid && w_ic_valid) begin
        if (r_starve_cnt >= c_STARVE_LIMIT) w_grant_ic = 1'b1;
        else                                w_grant_dc = 1'b1;
      end else if (w_dc_valid) begin
        w_grant_dc = 1'b1;
      end else if (w_ic_valid) begin
        w_grant_ic = 1'b1;
      end
    end
  end

  // Drive the memory port from the winner and steer the acceptance tag back to it.
  always_comb begin
    w_grant_cmd              = c_BUS_NONE;
    bus.proc2mem_command     = c_BUS_NONE;
    bus.proc2mem_addr        = '0;
    bus.proc2mem_data        = '0;
    bus.Ctlr2dcache_response = '0;
    bus.Ctlr2icache_response = '0;
    if (w_grant_dc) begin
      w_grant_cmd              = bus.dcache2ctlr_command;
      bus.proc2mem_command     = bus.dcache2ctlr_command;
      bus.proc2mem_addr        = bus.dcache2ctlr_addr;
      bus.proc2mem_data        = bus.dcache2ctlr_data;
      bus.Ctlr2dcache_response = bus.mem2proc_response;
    end else if (w_grant_ic) begin
      w_grant_cmd              = bus.icache2ctlr_command;
      bus.proc2mem_command     = bus.icache2ctlr_command;
      bus.proc2mem_addr        = bus.icache2ctlr_addr;
      bus.Ctlr2icache_response = bus.mem2proc_response;
    end
  end

  // Only accepted loads create an outstanding tag; stores complete silently.
  assign w_alloc = (w_grant_cmd == c_BUS_LOAD) && (bus.mem2proc_response != 4'd0);

  // Forward a completion to the owner recorded for its tag; unknown tags go nowhere.
  always_comb begin
    bus.Ctlr2dcache_tag  = '0;
    bus.Ctlr2dcache_data = '0;
    bus.Ctlr2icache_tag  = '0;
    bus.Ctlr2icache_data = '0;
    if (w_cpl_hit && !reset) begin
      if (r_tag_owner[bus.mem2proc_tag] == c_OWNER_IC) begin
        bus.Ctlr2icache_tag  = bus.mem2proc_tag;
        bus.Ctlr2icache_data = bus.mem2proc_data;
      end else begin
        bus.Ctlr2dcache_tag  = bus.mem2proc_tag;
        bus.Ctlr2dcache_data = bus.mem2proc_data;
      end
    end
  end

  // Next owner table: retire the completing tag first so a same-tag allocation wins.
  always_comb begin
    w_tag_valid_nxt   = r_tag_valid;
    w_tag_owner_nxt   = r_tag_owner;
    w_outstanding_nxt = 4'd0;
    if (w_cpl_hit) begin
      w_tag_valid_nxt[bus.mem2proc_tag] = 1'b0;
    end
    if (w_alloc) begin
      w_tag_valid_nxt[bus.mem2proc_response] = 1'b1;
      w_tag_owner_nxt[bus.mem2proc_response] = w_grant_ic ? c_OWNER_IC : c_OWNER_DC;
    end
    w_tag_valid_nxt[0] = 1'b0;
    for (int i = 1; i < 16; i++) begin
      w_outstanding_nxt = w_outstanding_nxt + {3'b000, w_tag_valid_nxt[i]};
    end
  end

  // Count consecutive cycles a waiting icache request loses to dcache.
  always_comb begin
    w_starve_nxt = 4'd0;
    if (w_ic_valid && w_grant_dc) begin
      w_starve_nxt = (r_starve_cnt == c_STARVE_MAX) ? c_STARVE_MAX : r_starve_cnt + 4'd1;
    end
  end

  // State update; reset forgets every in-flight tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_valid   <= '0;
      r_tag_owner   <= '0;
      r_starve_cnt  <= '0;
      r_outstanding <= '0;
      r_tag_error   <= 1'b0;
    end else begin
      r_tag_valid   <= w_tag_valid_nxt;
      r_tag_owner   <= w_tag_owner_nxt;
      r_starve_cnt  <= w_starve_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_cpl_valid && !w_cpl_hit) begin
        r_tag_error <= 1'b1;
      end
    end
  end

  assign bus.outstanding_cnt = r_outstanding;
  assign bus.tag_error       = r_tag_error;

endmodule
`default_nettype wire

// File: doc/mem_ctlr_arbiter.md
# mem_ctlr_arbiter

Arbitrates the single memory port between the instruction cache and the data cache. It forwards at most one request per cycle, returns the acceptance tag only to the requester that won, and tracks which requester owns each outstanding load tag. Completed load data is then steered to that owner. The block sits between the two caches and the memory model/bus; dcache and icache each see it as a private memory controller.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitration cycles after which a pending icache request overrides dcache priority; legal range 1..15.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- dcache2ctlr_command  in  2  dcache bus command: BUS_NONE, BUS_LOAD or BUS_STORE.
- dcache2ctlr_addr  in  XLEN  dcache request address, 8-byte aligned.
- dcache2ctlr_data  in  64  dcache store data.
- icache2ctlr_command  in  2  icache bus command; BUS_STORE is treated as BUS_NONE.
- icache2ctlr_addr  in  XLEN  icache request address, 8-byte aligned.
- proc2mem_command  out  2  command to memory.
- proc2mem_addr  out  XLEN  address to memory.
- proc2mem_data  out  64  store data to memory.
- mem2proc_response  in  4  acceptance tag; 0 = rejected.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  4  completion tag; 0 = none.
- Ctlr2dcache_response / Ctlr2dcache_data / Ctlr2dcache_tag  out  4/64/4  dcache-facing copy of the memory return.
- Ctlr2icache_response / Ctlr2icache_data / Ctlr2icache_tag  out  4/64/4  icache-facing copy of the memory return.
- outstanding_cnt  out  4  number of owned load tags currently in flight.
- tag_error  out  1  sticky flag: a completion arrived for a tag with no owner.

## Operation
- **Valid requests.**
  - dcache request valid when dcache2ctlr_command != BUS_NONE.
  - icache request valid when icache2ctlr_command == BUS_LOAD.
- **Grant (combinational), first match wins:**
  - reset high → no grant.
  - only one request valid → grant that requester.
  - both valid and starve_cnt >= STARVE_LIMIT → grant icache.
  - both valid otherwise → grant dcache.
- **Bus drive.** The granted requester's command, addr and data drive proc2mem_*. For an icache grant, proc2mem_data = 0. With no grant: BUS_NONE, addr 0, data 0.
- **Response steering.** mem2proc_response goes to the granted requester's Ctlr2*_response; the other side sees 0.
- **starve_cnt register**, width 4, saturating at 15:
  - +1 when icache is valid and dcache is granted.
  - cleared when icache is granted, or when icache is not valid.
- **Owner table**, 16 entries {valid, owner}; entry 0 is never used.
  - Allocation: the granted command is BUS_LOAD and mem2proc_response != 0 → entry[response] <= {1, granted requester}.
  - Accepted stores allocate nothing.
- **Completion:** mem2proc_tag != 0.
  - Entry valid → mem2proc_tag and mem2proc_data are forwarded combinationally to the owner's Ctlr2*_tag and Ctlr2*_data; the other side sees tag 0 and data 0. The entry is cleared at the clock edge.
  - Entry invalid → nothing is forwarded (both sides see tag 0) and tag_error <= 1.
- **Same tag completes and is re-allocated in one cycle:** allocation wins; the entry ends valid with the new owner. The completion is still forwarded to the old owner.
- **outstanding_cnt** = number of valid entries, computed as the registered population count.
  - Allocation and completion in the same cycle → net change 0.
- **Outputs during reset.**
  - proc2mem_command = BUS_NONE.
  - All Ctlr2*_response, Ctlr2*_tag and Ctlr2*_data = 0.
  - After the clock edge with reset high: owner table cleared, starve_cnt = 0, outstanding_cnt = 0, tag_error = 0.
- **Reset mid-operation.** In-flight tags are forgotten. A later completion for such a tag is dropped and sets tag_error, so memory must be reset together with this block.

## Timing
- Request → proc2mem_*: 0 cycles (combinational).
- mem2proc_response → Ctlr2*_response: 0 cycles, same cycle as the request.
  - A requester sees a nonzero response only in a cycle in which it was granted.
  - A losing requester holds its request and retries the next cycle; no buffering inside the block.
- mem2proc_tag/data → Ctlr2*_tag/data: 0 cycles.
  - Owner lookup uses the table state before this cycle's allocation.
- Owner table, starve_cnt, outstanding_cnt and tag_error update on the rising clock edge only.
- An icache request contending against continuous dcache traffic is granted no later than cycle STARVE_LIMIT+1 of contention.

## Test plan
- **Reset and idle.** Reset held 2 cycles, then all commands BUS_NONE.
  - Required: proc2mem_command = BUS_NONE, outstanding_cnt = 0, tag_error = 0, every Ctlr2* output = 0.
- **Single dcache load.** dcache BUS_LOAD at 0x1000; memory responds tag 3; 5 cycles later mem2proc_tag = 3 with data 0xDEADBEEF_CAFEF00D.
  - Required: Ctlr2dcache_response = 3 in the request cycle; Ctlr2icache_response = 0.
  - Required: data delivered on Ctlr2dcache only.
  - Required: outstanding_cnt goes 0 → 1 → 0.
- **Contention with starvation**, STARVE_LIMIT = 4. Both caches issue loads every cycle; memory always accepts.
  - Required: dcache granted in cycles 1–4; icache granted in cycle 5; starve_cnt then 0.
- **Store plus icache load in the same cycle.** dcache BUS_STORE, icache BUS_LOAD, memory responds tag 7.
  - Required: dcache receives the response.
  - Required: outstanding_cnt does not change.
  - Required: icache is granted the next cycle.
- **Unknown tag and tag reuse.**
  - mem2proc_tag = 9 with no owner → both Ctlr2*_tag = 0 and tag_error = 1, sticky.
  - Tag 2 owned by icache completes in the same cycle a new dcache load is accepted with tag 2 → the old data goes to icache, the entry's new owner is dcache, and outstanding_cnt is unchanged.
- **Reset mid-flight.** Three loads outstanding, reset asserted for 1 cycle.
  - Required: outstanding_cnt = 0 after the edge; a later return of one of those tags sets tag_error.
